// File: rtl/hclk_seq_pkg.sv
// rtl/hclk_seq_pkg.sv - shared state encoding, default timings and width helper for hclk_seq_ctrl
package hclk_seq_pkg;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_IDLE,
      ST_GATE,
      ST_DRST,
      ST_SETTLE
   } state_t;

   localparam int DEF_GATE_CYC   = 4;
   localparam int DEF_RST_CYC    = 8;
   localparam int DEF_SETTLE_CYC = 16;
   localparam int DEF_DWELL_W    = 30;

   function automatic int idx_w(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hclk_seq_timer.sv
// rtl/hclk_seq_timer.sv - loadable down-counter shared by the GATE, DRST and SETTLE phases
module hclk_seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/hclk_seq_ctrl.sv
// rtl/hclk_seq_ctrl.sv - glitch-safe divided-clock channel switch sequencer (gate, reset, settle, ungate)
module hclk_seq_ctrl
   import hclk_seq_pkg::*;
#(
   parameter int NUM_HCLK   = 4,
   parameter int GATE_CYC   = DEF_GATE_CYC,
   parameter int RST_CYC    = DEF_RST_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int DWELL_W    = DEF_DWELL_W,
   localparam int IW        = idx_w(NUM_HCLK)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                hold,
   input  logic                auto_en,
   input  logic                req_valid,
   input  logic [IW-1:0]       req_idx,
   output logic                req_ready,
   output logic                done,
   output logic                err,
   output logic                busy,
   output logic [IW-1:0]       sel_idx,
   output logic                hclk_ce,
   output logic [NUM_HCLK-1:0] div_resetn
);

   localparam int MAX_GR = (GATE_CYC > RST_CYC) ? GATE_CYC : RST_CYC;
   localparam int MAX_C  = (MAX_GR > SETTLE_CYC) ? MAX_GR : SETTLE_CYC;
   localparam int TW     = idx_w(MAX_C);
   localparam logic [IW:0]   NUM_L  = (IW + 1)'(NUM_HCLK);
   localparam logic [IW-1:0] LAST_L = IW'(NUM_HCLK - 1);

   state_t              state, next_state;
   logic                load;
   logic [TW-1:0]       load_val;
   logic                expire;
   logic                accept_ext, accept_int, out_of_range;
   logic [DWELL_W-1:0]  dwell;
   logic [IW-1:0]       target;
   logic [IW-1:0]       next_idx;
   logic                ext_flag;

   hclk_seq_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .resetn   (resetn),
      .load     (load),
      .load_val (load_val),
      .expire   (expire)
   );

   assign out_of_range = ({1'b0, req_idx} >= NUM_L);
   assign next_idx     = (sel_idx == LAST_L) ? '0 : sel_idx + 1'b1;

   always_comb begin
      next_state = state;
      load       = 1'b0;
      load_val   = '0;
      accept_ext = 1'b0;
      accept_int = 1'b0;
      case (state)
         ST_BOOT: begin
            next_state = ST_DRST;
            load       = 1'b1;
            load_val   = TW'(RST_CYC - 1);
         end
         ST_IDLE: begin
            if (req_ready && req_valid) begin
               accept_ext = 1'b1;
               if (!out_of_range) begin
                  next_state = ST_GATE;
                  load       = 1'b1;
                  load_val   = TW'(GATE_CYC - 1);
               end
            end else if (req_ready && auto_en && (&dwell)) begin
               accept_int = 1'b1;
               next_state = ST_GATE;
               load       = 1'b1;
               load_val   = TW'(GATE_CYC - 1);
            end
         end
         ST_GATE: begin
            if (expire) begin
               next_state = ST_DRST;
               load       = 1'b1;
               load_val   = TW'(RST_CYC - 1);
            end
         end
         ST_DRST: begin
            if (expire) begin
               next_state = ST_SETTLE;
               load       = 1'b1;
               load_val   = TW'(SETTLE_CYC - 1);
            end
         end
         ST_SETTLE: begin
            if (expire) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_BOOT;
      endcase
   end

   // Outputs are registered from next_state so each phase shows up on the cycle it occupies.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_BOOT;
         dwell      <= '0;
         target     <= '0;
         ext_flag   <= 1'b0;
         sel_idx    <= '0;
         hclk_ce    <= 1'b1;
         div_resetn <= '0;
         req_ready  <= 1'b0;
         busy       <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state <= next_state;
         if (accept_ext || accept_int) begin
            dwell <= '0;
         end else if (state == ST_IDLE && req_ready && auto_en) begin
            dwell <= dwell + 1'b1;
         end
         if (accept_ext && !out_of_range) begin
            target   <= req_idx;
            ext_flag <= 1'b1;
         end else if (accept_int) begin
            target   <= next_idx;
            ext_flag <= 1'b0;
         end
         if (next_state == ST_SETTLE && state != ST_SETTLE) begin
            sel_idx <= target;
         end
         hclk_ce    <= (next_state == ST_IDLE) ? hold : 1'b1;
         req_ready  <= (next_state == ST_IDLE) && !hold;
         div_resetn <= (next_state == ST_DRST) ? '0 : '1;
         busy       <= (next_state != ST_IDLE);
         done       <= (state == ST_SETTLE) && expire && ext_flag;
         err        <= accept_ext && out_of_range;
      end
   end

endmodule

// File: tb/tb_hclk_seq_ctrl.sv
// tb/tb_hclk_seq_ctrl.sv - randomized self-checking bench for hclk_seq_ctrl against a cycle-position model
module tb_hclk_seq_ctrl;

   // Five channels give a 3-bit index, so indices 5..7 exercise the out-of-range path.
   localparam int N  = 5;
   localparam int G  = 4;
   localparam int R  = 8;
   localparam int S  = 16;
   localparam int DW = 4;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          hold = 1'b0;
   logic          auto_en = 1'b0;
   logic          req_valid = 1'b0;
   logic [IW-1:0] req_idx = '0;
   logic          req_ready, done, err, busy, hclk_ce;
   logic [IW-1:0] sel_idx;
   logic [N-1:0]  div_resetn;

   int checks = 0;
   int failures = 0;

   // Model: a switch is a position count since its accept edge; phases follow from arithmetic on it.
   bit m_seq, m_ext, m_hold_s, m_done, m_err;
   int m_pos, m_tgt, m_sel, m_dwell;

   hclk_seq_ctrl #(
      .NUM_HCLK(N), .GATE_CYC(G), .RST_CYC(R), .SETTLE_CYC(S), .DWELL_W(DW)
   ) dut (
      .clk(clk), .resetn(resetn), .hold(hold), .auto_en(auto_en),
      .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
      .done(done), .err(err), .busy(busy), .sel_idx(sel_idx),
      .hclk_ce(hclk_ce), .div_resetn(div_resetn)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_seq = 1; m_pos = G; m_tgt = 0; m_ext = 0; m_sel = 0;
      m_dwell = 0; m_hold_s = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit rdy;
      m_done = 0;
      m_err  = 0;
      if (m_seq) begin
         m_pos++;
         if (m_pos == G + R + 1) m_sel = m_tgt;
         if (m_pos == G + R + S + 1) begin
            m_seq    = 0;
            m_done   = m_ext;
            m_hold_s = hold;
         end
      end else begin
         rdy = !m_hold_s;
         if (rdy && req_valid) begin
            m_dwell = 0;
            if (int'(req_idx) < N) begin
               m_tgt = int'(req_idx); m_ext = 1; m_seq = 1; m_pos = 1;
            end else begin
               m_err = 1;
            end
         end else if (rdy && auto_en && m_dwell == (1 << DW) - 1) begin
            m_dwell = 0;
            m_tgt = (m_sel + 1) % N; m_ext = 0; m_seq = 1; m_pos = 1;
         end else if (rdy && auto_en) begin
            m_dwell++;
         end
         m_hold_s = hold;
      end
   endtask

   task automatic compare_all();
      bit in_rst;
      in_rst = m_seq && m_pos >= G + 1 && m_pos <= G + R;
      check("busy", 32'(busy), 32'(m_seq));
      check("hclk_ce", 32'(hclk_ce), m_seq ? 32'd1 : 32'(m_hold_s));
      check("req_ready", 32'(req_ready), (!m_seq && !m_hold_s) ? 32'd1 : 32'd0);
      check("div_resetn", 32'(div_resetn), in_rst ? 32'd0 : 32'((1 << N) - 1));
      check("sel_idx", 32'(sel_idx), 32'(m_sel));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   // Called just after a negedge; reset takes effect asynchronously.
   task automatic do_reset();
      resetn = 1'b0;
      #1;
      check("rst_sel", 32'(sel_idx), 32'd0);
      check("rst_ce", 32'(hclk_ce), 32'd1);
      check("rst_divrst", 32'(div_resetn), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && m_seq; i++) step();
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic send(input int idx);
      for (int i = 0; i < 200 && (m_seq || m_hold_s); i++) step();
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_idx   = IW'(idx);
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      // Bring-up: DRST on cycles 1..8, SETTLE 9..24, IDLE at 25.
      repeat (30) step();

      send(2);
      repeat (6) step();
      hold = 1'b1;
      step();
      hold = 1'b0;
      wait_idle();
      repeat (2) step();

      send(5);
      repeat (3) step();

      send(4);
      wait_idle();
      auto_en = 1'b1;
      for (int i = 0; i < 40 && !m_seq; i++) step();
      check("auto_start", 32'(busy), 32'd1);
      wait_idle();
      check("auto_wrap", 32'(sel_idx), 32'd0);

      // External request lands on the same edge the dwell counter would wrap.
      for (int i = 0; i < 40 && !(m_dwell == (1 << DW) - 1 && !m_seq); i++) step();
      req_valid = 1'b1;
      req_idx   = 3'd2;
      step();
      req_valid = 1'b0;
      wait_idle();
      check("ext_wins", 32'(sel_idx), 32'd2);

      hold = 1'b1;
      repeat (10) step();
      hold = 1'b0;
      repeat (3) step();
      auto_en = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         req_valid = ($urandom_range(0, 7) == 0);
         req_idx   = IW'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) hold = ~hold;
         if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
         step();
      end
      hold = 1'b0; auto_en = 1'b0; req_valid = 1'b0;
      wait_idle();

      send(1);
      for (int i = 0; i < 40 && !(m_seq && m_pos == G + 3); i++) step();
      check("drst3_reach", 32'(div_resetn), 32'd0);
      do_reset();
      repeat (30) step();
      check("abort_sel", 32'(sel_idx), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
